// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI mode-0 register-bank responder.
// State encoding, command-byte field positions and the fixed ID address.
package spi_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam logic [3:0] WHOAMI_ADDR = 4'hF;
   localparam int         CMD_RW_BIT  = 7;
   localparam int         CMD_MS_BIT  = 6;
   localparam int         NUM_REGS    = 15;

   // Burst addressing: advance only in multi-byte mode, wrapping 0xF -> 0x0.
   function automatic logic [3:0] next_addr(input logic [3:0] addr, input logic ms);
      return ms ? addr + 4'd1 : addr;
   endfunction

endpackage

// File: rtl/spi_responder_if.sv
// Pin-level bundle for spi_responder: SPI wires, local load port and write report.
// The responder takes the slave view; the bench or board logic takes the master view.
interface spi_responder_if;

   logic       SPI_SCK;
   logic       SPI_CSN;
   logic       SPI_MOSI;
   logic       SPI_MISO;
   logic       SPI_MISO_OE;
   logic       LD_EN;
   logic [3:0] LD_ADDR;
   logic [7:0] LD_DATA;
   logic       WR_STB;
   logic [3:0] WR_ADDR;
   logic [7:0] WR_DATA;
   logic       BUSY;

   modport slave (
      input  SPI_SCK, SPI_CSN, SPI_MOSI, LD_EN, LD_ADDR, LD_DATA,
      output SPI_MISO, SPI_MISO_OE, WR_STB, WR_ADDR, WR_DATA, BUSY
   );

   modport master (
      output SPI_SCK, SPI_CSN, SPI_MOSI, LD_EN, LD_ADDR, LD_DATA,
      input  SPI_MISO, SPI_MISO_OE, WR_STB, WR_ADDR, WR_DATA, BUSY
   );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus a history flop that
// yields single-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge #(
   parameter logic RST_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic srst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_reg;
   logic sync_reg;
   logic prev_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         meta_reg <= RST_LEVEL;
         sync_reg <= RST_LEVEL;
         prev_reg <= RST_LEVEL;
      end else begin
         meta_reg <= din;
         sync_reg <= meta_reg;
         prev_reg <= sync_reg;
      end
   end

   assign level = sync_reg;
   assign rise  = sync_reg & ~prev_reg;
   assign fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 slave exposing a 16x8 register bank with LIS3DH-style commands,
// a local load port and a per-byte write strobe.
module spi_responder
   import spi_responder_pkg::*;
#(
   parameter logic [7:0] WHOAMI = 8'h33,
   parameter logic [7:0] RSTVAL = 8'h00
) (
   input  logic           CLK,
   input  logic           RES,
   spi_responder_if.slave bus
);

   logic sck_rise, sck_fall, sck_level_unused;
   logic csn_level, csn_rise, csn_fall;
   logic mosi_meta_reg, mosi_sync_reg;
   logic armed_reg;

   // CSN syncs reset low so that a CSN still low after reset never produces a
   // falling edge; armed_reg then waits to see CSN high before accepting a start.
   spi_sync_edge #(.RST_LEVEL(1'b0)) u_sync_sck (
      .clk   (CLK),
      .srst  (RES),
      .din   (bus.SPI_SCK),
      .level (sck_level_unused),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   spi_sync_edge #(.RST_LEVEL(1'b0)) u_sync_csn (
      .clk   (CLK),
      .srst  (RES),
      .din   (bus.SPI_CSN),
      .level (csn_level),
      .rise  (csn_rise),
      .fall  (csn_fall)
   );

   always_ff @(posedge CLK) begin
      if (RES) begin
         mosi_meta_reg <= 1'b0;
         mosi_sync_reg <= 1'b0;
         armed_reg     <= 1'b0;
      end else begin
         mosi_meta_reg <= bus.SPI_MOSI;
         mosi_sync_reg <= mosi_meta_reg;
         if (csn_level) begin
            armed_reg <= 1'b1;
         end
      end
   end

   state_t     state_reg,     state_next;
   logic [2:0] bit_cnt_reg,   bit_cnt_next;
   logic [7:0] in_shift_reg,  in_shift_next;
   logic [7:0] out_shift_reg, out_shift_next;
   logic [3:0] addr_reg,      addr_next;
   logic       rw_reg,        rw_next;
   logic       ms_reg,        ms_next;
   logic       miso_reg,      miso_next;
   logic       wr_stb_reg,    wr_stb_next;
   logic [3:0] wr_addr_reg,   wr_addr_next;
   logic [7:0] wr_data_reg,   wr_data_next;
   logic       commit_en;

   logic [7:0] regs_mem [NUM_REGS];
   logic [7:0] shift_in;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;

   assign shift_in = {in_shift_reg[6:0], mosi_sync_reg};

   // The only shifter loads are at the end of a command byte (new address) and
   // at the end of a read data byte (advanced address), so one read port suffices.
   assign rd_addr = (state_reg == ST_CMD) ? shift_in[3:0] : next_addr(addr_reg, ms_reg);
   assign rd_data = (rd_addr == WHOAMI_ADDR) ? WHOAMI : regs_mem[rd_addr];

   always_ff @(posedge CLK) begin
      if (RES) begin
         state_reg     <= ST_IDLE;
         bit_cnt_reg   <= 3'd0;
         in_shift_reg  <= 8'h00;
         out_shift_reg <= 8'h00;
         addr_reg      <= 4'h0;
         rw_reg        <= 1'b0;
         ms_reg        <= 1'b0;
         miso_reg      <= 1'b0;
         wr_stb_reg    <= 1'b0;
         wr_addr_reg   <= 4'h0;
         wr_data_reg   <= 8'h00;
      end else begin
         state_reg     <= state_next;
         bit_cnt_reg   <= bit_cnt_next;
         in_shift_reg  <= in_shift_next;
         out_shift_reg <= out_shift_next;
         addr_reg      <= addr_next;
         rw_reg        <= rw_next;
         ms_reg        <= ms_next;
         miso_reg      <= miso_next;
         wr_stb_reg    <= wr_stb_next;
         wr_addr_reg   <= wr_addr_next;
         wr_data_reg   <= wr_data_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      bit_cnt_next   = bit_cnt_reg;
      in_shift_next  = in_shift_reg;
      out_shift_next = out_shift_reg;
      addr_next      = addr_reg;
      rw_next        = rw_reg;
      ms_next        = ms_reg;
      miso_next      = miso_reg;
      wr_stb_next    = 1'b0;
      wr_addr_next   = wr_addr_reg;
      wr_data_next   = wr_data_reg;
      commit_en      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            miso_next = 1'b0;
            if (csn_fall && armed_reg) begin
               state_next   = ST_CMD;
               bit_cnt_next = 3'd0;
            end
         end

         ST_CMD: begin
            miso_next = 1'b0;
            if (sck_rise) begin
               in_shift_next = shift_in;
               bit_cnt_next  = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) begin
                  addr_next  = shift_in[3:0];
                  rw_next    = shift_in[CMD_RW_BIT];
                  ms_next    = shift_in[CMD_MS_BIT];
                  state_next = ST_DATA;
                  if (shift_in[CMD_RW_BIT]) begin
                     out_shift_next = rd_data;
                  end
               end
            end
         end

         ST_DATA: begin
            if (rw_reg) begin
               // The trailing fall of each byte presents bit 7 of the next one.
               if (sck_fall) begin
                  miso_next      = out_shift_reg[7];
                  out_shift_next = {out_shift_reg[6:0], 1'b0};
               end
               if (sck_rise) begin
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) begin
                     addr_next      = next_addr(addr_reg, ms_reg);
                     out_shift_next = rd_data;
                  end
               end
            end else begin
               miso_next = 1'b0;
               if (sck_rise) begin
                  in_shift_next = shift_in;
                  bit_cnt_next  = bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) begin
                     commit_en    = (addr_reg != WHOAMI_ADDR);
                     wr_stb_next  = 1'b1;
                     wr_addr_next = addr_reg;
                     wr_data_next = shift_in;
                     addr_next    = next_addr(addr_reg, ms_reg);
                  end
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (csn_rise) begin
         state_next = ST_IDLE;
      end
   end

   // Per-register write selects; an SPI commit takes priority over a local load.
   logic [NUM_REGS-1:0] commit_sel;
   logic [NUM_REGS-1:0] load_sel;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_sel
         assign commit_sel[gi] = commit_en && (addr_reg == 4'(gi));
         assign load_sel[gi]   = bus.LD_EN && (bus.LD_ADDR == 4'(gi));
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RES) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_mem[i] <= RSTVAL;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_sel[i]) begin
               regs_mem[i] <= shift_in;
            end else if (load_sel[i]) begin
               regs_mem[i] <= bus.LD_DATA;
            end
         end
      end
   end

   assign bus.SPI_MISO    = miso_reg;
   assign bus.SPI_MISO_OE = armed_reg & ~csn_level;
   assign bus.BUSY        = armed_reg & ~csn_level;
   assign bus.WR_STB      = wr_stb_reg;
   assign bus.WR_ADDR     = wr_addr_reg;
   assign bus.WR_DATA     = wr_data_reg;

endmodule

// File: tb/tb_spi_responder.sv
// Directed plus randomized transactions against a register-bank model that
// applies the command/burst/commit rules directly to a 16-entry array.
module tb_spi_responder;

   localparam logic [7:0] WHOAMI_T = 8'h33;
   localparam logic [7:0] RSTVAL_T = 8'h5C;

   logic clk;
   logic res;
   int   vectors;
   int   miscompares;

   logic [7:0]  mdl [16];
   logic [11:0] stb_q [$];
   logic [11:0] exp_q [$];

   spi_responder_if bus ();

   spi_responder #(.WHOAMI(WHOAMI_T), .RSTVAL(RSTVAL_T)) dut (
      .CLK (clk),
      .RES (res),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.WR_STB === 1'b1) stb_q.push_back({bus.WR_ADDR, bus.WR_DATA});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] mdl_rd(input logic [3:0] a);
      return (a == 4'hF) ? WHOAMI_T : mdl[a];
   endfunction

   task automatic mdl_reset();
      for (int i = 0; i < 15; i++) mdl[i] = RSTVAL_T;
   endtask

   task automatic check_strobes(input string tag);
      check({tag, " strobe count"}, stb_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < stb_q.size(); i++)
         check({tag, " strobe"}, stb_q[i], exp_q[i]);
      stb_q.delete();
      exp_q.delete();
   endtask

   task automatic local_load(input logic [3:0] a, input logic [7:0] d);
      bus.LD_ADDR = a;
      bus.LD_DATA = d;
      bus.LD_EN   = 1'b1;
      @(negedge clk);
      bus.LD_EN   = 1'b0;
      if (a != 4'hF) mdl[a] = d;
   endtask

   // Mode 0, SCK period 10 clk. Optional local load aligned with the 8th rise commit.
   task automatic spi_bits(input logic [7:0] tx, input int n, input bit collide,
                           input logic [3:0] la, input logic [7:0] ld,
                           output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < n; i++) begin
         bus.SPI_MOSI = tx[7-i];
         repeat (5) @(negedge clk);
         rx[7-i] = bus.SPI_MISO;
         bus.SPI_SCK = 1'b1;
         if (collide && i == 7) begin
            repeat (2) @(negedge clk);
            bus.LD_ADDR = la;
            bus.LD_DATA = ld;
            bus.LD_EN   = 1'b1;
            @(negedge clk);
            bus.LD_EN   = 1'b0;
            repeat (2) @(negedge clk);
         end else begin
            repeat (5) @(negedge clk);
         end
         bus.SPI_SCK = 1'b0;
      end
   endtask

   task automatic spi_begin();
      bus.SPI_CSN = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic spi_end();
      repeat (4) @(negedge clk);
      bus.SPI_CSN = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic spi_read(input logic [7:0] cmd, input int n, input string tag);
      logic [7:0] rx;
      logic [3:0] a;
      a = cmd[3:0];
      spi_begin();
      spi_bits(cmd, 8, 1'b0, 4'h0, 8'h00, rx);
      for (int k = 0; k < n; k++) begin
         spi_bits(8'($urandom), 8, 1'b0, 4'h0, 8'h00, rx);
         check(tag, rx, mdl_rd(a));
         if (cmd[6]) a = a + 4'd1;
      end
      spi_end();
   endtask

   task automatic spi_write(input logic [7:0] cmd, input int n, input logic [23:0] wd,
                            input bit collide, input logic [7:0] ld, input string tag);
      logic [7:0] rx;
      logic [7:0] d;
      logic [3:0] a;
      a = cmd[3:0];
      spi_begin();
      spi_bits(cmd, 8, 1'b0, 4'h0, 8'h00, rx);
      for (int k = 0; k < n; k++) begin
         d = wd[23-8*k -: 8];
         spi_bits(d, 8, collide && k == 0, a, ld, rx);
         exp_q.push_back({a, d});
         if (a != 4'hF) mdl[a] = d;
         if (cmd[6]) a = a + 4'd1;
      end
      spi_end();
      check_strobes(tag);
   endtask

   initial begin
      logic [7:0] rx;
      logic [7:0] cmd;
      int n;
      vectors     = 0;
      miscompares = 0;
      bus.SPI_SCK  = 1'b0;
      bus.SPI_CSN  = 1'b1;
      bus.SPI_MOSI = 1'b0;
      bus.LD_EN    = 1'b0;
      bus.LD_ADDR  = 4'h0;
      bus.LD_DATA  = 8'h00;
      res = 1'b1;
      repeat (3) @(negedge clk);
      check("reset miso", bus.SPI_MISO, 0);
      check("reset oe", bus.SPI_MISO_OE, 0);
      check("reset wr_stb", bus.WR_STB, 0);
      check("reset wr_addr", bus.WR_ADDR, 0);
      check("reset wr_data", bus.WR_DATA, 0);
      check("reset busy", bus.BUSY, 0);
      res = 1'b0;
      mdl_reset();
      repeat (6) @(negedge clk);

      // WHOAMI read with OE/BUSY around the select window
      spi_begin();
      check("whoami oe during", bus.SPI_MISO_OE, 1);
      check("whoami busy during", bus.BUSY, 1);
      spi_bits(8'h8F, 8, 1'b0, 4'h0, 8'h00, rx);
      spi_bits(8'h00, 8, 1'b0, 4'h0, 8'h00, rx);
      check("whoami byte", rx, WHOAMI_T);
      spi_end();
      check("whoami oe after", bus.SPI_MISO_OE, 0);
      check("whoami busy after", bus.BUSY, 0);

      spi_write(8'h42, 2, {8'hA5, 8'h5A, 8'h00}, 1'b0, 8'h00, "burst write");
      spi_read(8'hC2, 2, "burst readback");

      local_load(4'hE, 8'h11);
      spi_read(8'hCE, 3, "wrap read");

      // Abort a write after 5 data bits
      local_load(4'h4, 8'h3C);
      spi_begin();
      spi_bits(8'h04, 8, 1'b0, 4'h0, 8'h00, rx);
      spi_bits(8'hFF, 5, 1'b0, 4'h0, 8'h00, rx);
      repeat (4) @(negedge clk);
      bus.SPI_CSN = 1'b1;
      @(negedge clk);
      check("abort busy 1clk", bus.BUSY, 1);
      @(negedge clk);
      check("abort busy 2clk", bus.BUSY, 0);
      repeat (8) @(negedge clk);
      check_strobes("abort");
      spi_read(8'h84, 1, "abort reg4");

      spi_write(8'h06, 1, {8'h01, 16'h0000}, 1'b1, 8'hFF, "collision");
      spi_read(8'h86, 1, "collision reg6");

      // Reset during the second byte of a read
      spi_write(8'h40, 2, {8'h77, 8'h88, 8'h00}, 1'b0, 8'h00, "pre-reset write");
      spi_begin();
      spi_bits(8'hC0, 8, 1'b0, 4'h0, 8'h00, rx);
      spi_bits(8'h00, 8, 1'b0, 4'h0, 8'h00, rx);
      check("pre-reset read", rx, 8'h77);
      spi_bits(8'h00, 3, 1'b0, 4'h0, 8'h00, rx);
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      mdl_reset();
      check("midreset miso", bus.SPI_MISO, 0);
      check("midreset oe", bus.SPI_MISO_OE, 0);
      check("midreset busy", bus.BUSY, 0);
      check("midreset wr_stb", bus.WR_STB, 0);
      spi_bits(8'hFF, 5, 1'b0, 4'h0, 8'h00, rx);
      spi_bits(8'h03, 8, 1'b0, 4'h0, 8'h00, rx);
      spi_bits(8'hAB, 8, 1'b0, 4'h0, 8'h00, rx);
      check("ignored busy", bus.BUSY, 0);
      check("ignored oe", bus.SPI_MISO_OE, 0);
      spi_end();
      check_strobes("ignored");
      spi_read(8'hC0, 2, "post-reset read");

      // Randomized traffic
      for (int t = 0; t < 24; t++) begin
         if ($urandom_range(1, 0) == 1) local_load(4'($urandom), 8'($urandom));
         cmd = 8'($urandom);
         n   = $urandom_range(3, 1);
         if (cmd[7]) spi_read(cmd, n, "rand read");
         else spi_write(cmd, n, 24'($urandom), 1'b0, 8'h00, "rand write");
      end
      spi_read(8'hC0, 3, "final sweep a");
      spi_read(8'hC8, 3, "final sweep b");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_responder.md
# spi_responder

SPI mode-0 slave for simulation and loopback on the MAX10 board. It is the target end of the darksocv SPI master (SPI_SCK/SPI_MOSI/SPI_MISO/SPI_CSN). It holds a 16×8 register bank addressed with LIS3DH-style command bytes, so SoC SPI firmware can be exercised without the on-board sensor. A local load port lets board logic, such as pmod buttons, place values into the bank, and a write strobe reports every SPI write.

## Interface
Parameters:
- WHOAMI, default 8'h33: value returned at address 0xF. Address 0xF is read-only.
- RSTVAL, default 8'h00: reset value of registers 0x0–0xE.

Ports. One clock; reset is synchronous and active-high.
- CLK  in  1  system clock; must be ≥ 8× SPI_SCK frequency.
- RES  in  1  synchronous active-high reset.
- SPI_SCK  in  1  SPI clock from the master; asynchronous to CLK.
- SPI_CSN  in  1  chip select, active low; asynchronous.
- SPI_MOSI  in  1  master data; asynchronous.
- SPI_MISO  out  1  slave data.
- SPI_MISO_OE  out  1  MISO output enable; high only while selected.
- LD_EN  in  1  local load strobe.
- LD_ADDR  in  4  local load address.
- LD_DATA  in  8  local load data.
- WR_STB  out  1  one-CLK pulse per completed SPI write byte.
- WR_ADDR  out  4  address of that write; valid while WR_STB is high.
- WR_DATA  out  8  data of that write; valid while WR_STB is high.
- BUSY  out  1  high while a transaction is active (synchronized CSN low).

## Operation
- **Synchronization:** SCK, CSN and MOSI each pass through a 2-flop synchronizer. Edge detect on synchronized SCK produces `rise` and `fall` pulses. MOSI is sampled on `rise`. MISO changes on `fall`.
- **States:** IDLE, CMD, DATA.
  - IDLE → CMD on synchronized CSN falling. Bit counter clears to 0.
  - CMD collects 8 bits, MSB first, into {RW, MS, A[5:0]}. Only A[3:0] is used; A[5:4] is ignored. On the 8th `rise`: latch addr = A[3:0], rw, ms; go to DATA.
  - When rw = 1, the read shifter also loads reg[addr] on that same `rise`.
  - DATA, read (rw = 1):
    - The next `fall` drives shifter bit 7. Each later `fall` shifts left.
    - After each 8th `rise`: if ms = 1, addr increments, wrapping 0xF → 0x0; the shifter reloads reg[addr].
  - DATA, write (rw = 0):
    - MOSI shifts in on `rise`.
    - On the 8th `rise`, commit the byte to reg[addr] unless addr = 0xF. Pulse WR_STB with WR_ADDR/WR_DATA regardless of address.
    - Then addr increments if ms = 1.
  - Any state → IDLE on synchronized CSN rising. A partial byte (fewer than 8 bits) is discarded, with no commit and no strobe.
- **Register 0xF** always reads WHOAMI. LD_EN to 0xF is ignored.
- **LD_EN** writes LD_DATA to LD_ADDR on the same CLK edge. If an SPI commit to the same address occurs in the same cycle, the SPI commit wins. A load does not alter a byte already latched in the read shifter.
- **MISO in CMD state:** drives 0.
- **SPI_MISO_OE** equals NOT synchronized CSN.
- **Reset mid-transaction:**
  - State → IDLE, registers → RSTVAL.
  - The current CSN-low period is ignored. A new transaction starts only after CSN is seen high and then low again.

## Timing
- **Reset values:** SPI_MISO = 0, SPI_MISO_OE = 0, WR_STB = 0, WR_ADDR = 0, WR_DATA = 0, BUSY = 0. Registers 0x0–0xE = RSTVAL.
- **Input latency:** 2 CLK from an SCK pin edge to its `rise`/`fall` pulse.
- **Outputs after an edge pulse:**
  - SPI_MISO updates 1 CLK after the `fall` pulse, i.e. ≤ 4 CLK after the SCK pin edge. This is within the half period guaranteed by the 8× ratio.
  - WR_STB asserts 1 CLK after the 8th data `rise` pulse and lasts exactly 1 CLK.
  - BUSY and SPI_MISO_OE follow the CSN pin with 2 CLK latency.
- **Read first-bit rule:** the first read bit must be on MISO before the master's first data-byte `rise`. The command byte's trailing `fall` satisfies this.

## Structure
- **Package `spi_responder_pkg`:**
  - State encoding: IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2.
  - WHOAMI address constant 4'hF.
  - Command bit positions: RW = 7, MS = 6.
- **Sub-module `spi_sync_edge`:**
  - 2-flop synchronizer, plus a third flop for edge detect.
  - Outputs: level, rise, fall.
  - Instantiated for SCK and CSN. MOSI uses only the level output.
- **Top:** FSM, 3-bit bit counter, 8-bit in/out shifters, 15×8 register array, mux for address 0xF.

## Test plan
- Read WHOAMI: send command 0x8F, then 8 dummy clocks → MISO byte = 0x33. SPI_MISO_OE high only during CSN low.
- Burst write: command 0x42 (write, ms = 1, addr 2), data 0xA5, 0x5A → reg2 = A5, reg3 = 5A. Two WR_STB pulses with (2, A5) and (3, 5A).
- Burst read with wrap: preload reg14 = 0x11 via LD_EN, then command 0xCE, read 3 bytes → 0x11, 0x33, RSTVAL (reg0); the address wraps F → 0.
- Abort: command 0x04 (write, addr 4), then 5 data bits, then CSN high → reg4 unchanged, no WR_STB, BUSY low 2 CLK after CSN.
- Collision: LD_EN to addr 6 with 0xFF in the same cycle as an SPI commit of 0x01 to addr 6 → reg6 = 0x01.
- Reset mid-read: assert RES for 1 CLK during byte 2 of a read → outputs at reset values; the remaining clocks are ignored until CSN cycles high then low.
